// File: rtl/dca_matrix_lsu_inst_queue_pkg.sv
// Shared definitions for the matrix LSU instruction queue.
//   BW_DCA_MATRIX_LSU_INST : default instruction word width
//   iq_state_e             : issue/fence controller states
//   clog2_f                : ceil(log2) helper for port and counter widths
package dca_matrix_lsu_inst_queue_pkg;

  localparam int unsigned BW_DCA_MATRIX_LSU_INST = 32;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_FENCE_DRAIN = 2'd1,
    ST_FENCE_WAIT  = 2'd2
  } iq_state_e;

  // Number of bits needed to index 'value' distinct items (0 for value <= 1).
  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem != 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dca_inst_sync_fifo.sv
// Generic single-clock FIFO with synchronous clear, DEPTH x BW entries.
// Head data is read combinationally from storage; pointers carry one extra
// wrap bit so full/empty come from comparing the MSBs.
//   clk, rst      : clock, asynchronous active-high reset
//   i_clear       : synchronous flush (pointers to zero), wins over push/pop
//   i_push        : write i_push_data at tail (ignored when full)
//   i_pop         : drop head entry (ignored when empty)
//   o_pop_data    : head entry
//   o_full/o_empty: occupancy flags
//   o_count       : number of stored entries
module dca_inst_sync_fifo
  import dca_matrix_lsu_inst_queue_pkg::*;
#(
  parameter int unsigned BW    = BW_DCA_MATRIX_LSU_INST,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = clog2_f(DEPTH),
  localparam int unsigned PW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic [BW-1:0] i_push_data,
  input  logic          i_pop,
  output logic [BW-1:0] o_pop_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [PW-1:0] o_count
);

  logic [BW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  // Same index with opposite wrap bit means the writer is a full lap ahead.
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count    = r_wr_ptr - r_rd_ptr;
  assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

  assign w_do_push  = i_push && !o_full && !i_clear;
  assign w_do_pop   = i_pop && !o_empty && !i_clear;

  // Pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage; reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[AW'(i)] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

endmodule

// File: rtl/dca_matrix_lsu_inst_queue.sv
// Instruction buffer and issue controller in front of the matrix LSU.
// Buffers instructions in a FIFO, issues them over a valid/ready handshake,
// limits issued-but-unexecuted instructions with a credit counter, and
// implements a fence that drains the queue and waits for all executions.
//   clk, rst                 : clock, asynchronous active-high reset
//   i_clear                  : synchronous flush of all state
//   i_push_valid/data        : instruction from control side
//   o_push_ready             : FIFO not full
//   i_sync_req / o_sync_done : fence request / single-cycle completion
//   o_inst_wvalid/wdata      : head instruction to LSU
//   i_inst_wready            : LSU accepts head instruction
//   i_inst_decode_finish     : one pulse per decoded instruction
//   i_inst_execute_finish    : one pulse per executed instruction
//   o_busy                   : queue non-empty, inflight, or fence pending
//   o_num_queued / o_num_inflight / o_num_undecoded : status counts
//   o_error                  : sticky, finish pulse with nothing outstanding
module dca_matrix_lsu_inst_queue
  import dca_matrix_lsu_inst_queue_pkg::*;
#(
  parameter int unsigned BW_INST      = BW_DCA_MATRIX_LSU_INST,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_INFLIGHT = 2,
  localparam int unsigned QW          = clog2_f(DEPTH + 1),
  localparam int unsigned FW          = clog2_f(MAX_INFLIGHT + 1),
  localparam int unsigned PW          = clog2_f(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_push_valid,
  input  logic [BW_INST-1:0] i_push_data,
  output logic               o_push_ready,
  input  logic               i_sync_req,
  output logic               o_sync_done,
  output logic               o_inst_wvalid,
  output logic [BW_INST-1:0] o_inst_wdata,
  input  logic               i_inst_wready,
  input  logic               i_inst_decode_finish,
  input  logic               i_inst_execute_finish,
  output logic               o_busy,
  output logic [QW-1:0]      o_num_queued,
  output logic [FW-1:0]      o_num_inflight,
  output logic [FW-1:0]      o_num_undecoded,
  output logic               o_error
);

  iq_state_e          r_state;
  iq_state_e          w_state_nxt;
  logic [FW-1:0]      r_num_inflight;
  logic [FW-1:0]      r_num_undecoded;
  logic               r_error;
  logic [FW-1:0]      w_inflight_nxt;
  logic [FW-1:0]      w_undecoded_nxt;
  logic               w_err_set;

  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [BW_INST-1:0] w_fifo_rdata;
  logic [PW-1:0]      w_fifo_count;
  logic               w_push;
  logic               w_issue;
  logic               w_credit;

  assign w_credit = (r_num_inflight < FW'(MAX_INFLIGHT));
  assign w_push   = i_push_valid && !w_fifo_full && !i_clear;
  assign w_issue  = o_inst_wvalid && i_inst_wready && !i_clear;

  dca_inst_sync_fifo #(
    .BW    (BW_INST),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (i_clear),
    .i_push      (w_push),
    .i_push_data (i_push_data),
    .i_pop       (w_issue),
    .o_pop_data  (w_fifo_rdata),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // Credit counters: a finish with nothing outstanding flags an error and
  // does not decrement, so the counter never wraps below zero.
  always_comb begin
    w_inflight_nxt  = r_num_inflight;
    w_undecoded_nxt = r_num_undecoded;
    w_err_set       = 1'b0;
    if (w_issue) begin
      w_inflight_nxt  = w_inflight_nxt + FW'(1);
      w_undecoded_nxt = w_undecoded_nxt + FW'(1);
    end
    if (i_inst_execute_finish) begin
      if (r_num_inflight == '0) w_err_set = 1'b1;
      else                      w_inflight_nxt = w_inflight_nxt - FW'(1);
    end
    if (i_inst_decode_finish) begin
      if (r_num_undecoded == '0) w_err_set = 1'b1;
      else                       w_undecoded_nxt = w_undecoded_nxt - FW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num_inflight  <= '0;
      r_num_undecoded <= '0;
      r_error         <= 1'b0;
    end else if (i_clear) begin
      r_num_inflight  <= '0;
      r_num_undecoded <= '0;
      r_error         <= 1'b0;
    end else begin
      r_num_inflight  <= w_inflight_nxt;
      r_num_undecoded <= w_undecoded_nxt;
      r_error         <= r_error | w_err_set;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_state <= ST_RUN;
    else if (i_clear) r_state <= ST_RUN;
    else              r_state <= w_state_nxt;
  end

  // FSM next state; sync_req is only honoured in RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:         if (i_sync_req)             w_state_nxt = ST_FENCE_DRAIN;
      ST_FENCE_DRAIN: if (w_fifo_empty)           w_state_nxt = ST_FENCE_WAIT;
      ST_FENCE_WAIT:  if (r_num_inflight == '0)   w_state_nxt = ST_RUN;
      default:                                    w_state_nxt = ST_RUN;
    endcase
  end

  // FSM outputs; issue continues while draining, stops while waiting.
  always_comb begin
    o_inst_wvalid = !w_fifo_empty && w_credit && (r_state != ST_FENCE_WAIT);
    o_sync_done   = (r_state == ST_FENCE_WAIT) && (r_num_inflight == '0) && !i_clear;
    o_busy        = !w_fifo_empty || (r_num_inflight != '0) || (r_state != ST_RUN);
  end

  assign o_inst_wdata    = w_fifo_rdata;
  assign o_push_ready    = !w_fifo_full;
  assign o_num_queued    = QW'(w_fifo_count);
  assign o_num_inflight  = r_num_inflight;
  assign o_num_undecoded = r_num_undecoded;
  assign o_error         = r_error;

endmodule
